// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: round-robin arbiter giving N requesters one-at-a-time access to a single memory port
module mem_rr_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 64,
    localparam int BE_W      = DATA_WIDTH / 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ-1:0]            req_we_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
    input  logic [NUM_REQ*BE_W-1:0]       req_be_i,
    output logic [NUM_REQ-1:0]            resp_valid_o,
    output logic [DATA_WIDTH-1:0]         resp_rdata_o,
    output logic                          resp_err_o,
    output logic                          mem_req_valid_o,
    input  logic                          mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0]         mem_addr_o,
    output logic                          mem_we_o,
    output logic [DATA_WIDTH-1:0]         mem_wdata_o,
    output logic [BE_W-1:0]               mem_be_o,
    input  logic                          mem_resp_valid_i,
    input  logic [DATA_WIDTH-1:0]         mem_rdata_i,
    input  logic                          mem_err_i,
    output logic                          stale_resp_o
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         rr_ptr_q, owner_q, grant, idx;
    logic [PW:0]           sum;
    logic                  grant_valid, timeout;
    logic [7:0]            cnt_q;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  sel_we;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [BE_W-1:0]       sel_be;

    assign timeout         = cnt_q == 8'(TIMEOUT - 1);
    assign mem_req_valid_o = state_q == ISSUE;
    assign req_ready_o     = (state_q == IDLE && grant_valid) ? NUM_REQ'(1) << grant : '0;
    assign resp_valid_o    = (state_q == RESP) ? NUM_REQ'(1) << owner_q : '0;

    // first valid requester searching upward from rr_ptr, wrapping at NUM_REQ-1
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        sum         = '0;
        idx         = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, rr_ptr_q} + (PW+1)'(i);
            sum = (sum >= (PW+1)'(NUM_REQ)) ? sum - (PW+1)'(NUM_REQ) : sum;
            idx = sum[PW-1:0];
            if (!grant_valid && req_valid_i[idx]) begin
                grant_valid = 1'b1;
                grant       = idx;
            end
        end
    end

    // payload mux for the granted requester
    always_comb begin
        sel_addr  = '0;
        sel_we    = 1'b0;
        sel_wdata = '0;
        sel_be    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant == PW'(i)) begin
                sel_addr  = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_we    = req_we_i[i];
                sel_wdata = req_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
                sel_be    = req_be_i[i*BE_W +: BE_W];
            end
        end
    end

    // state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // next state: a response in the last WAIT cycle beats the timeout since both go to RESP
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = grant_valid ? ISSUE : IDLE;
            ISSUE:   state_d = mem_req_ready_i ? WAIT : ISSUE;
            WAIT:    state_d = (mem_resp_valid_i || timeout) ? RESP : WAIT;
            default: state_d = IDLE;
        endcase
    end

    // grant bookkeeping, payload latch, wait counter, response capture and stale flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            cnt_q        <= '0;
            mem_addr_o   <= '0;
            mem_we_o     <= 1'b0;
            mem_wdata_o  <= '0;
            mem_be_o     <= '0;
            resp_rdata_o <= '0;
            resp_err_o   <= 1'b0;
            stale_resp_o <= 1'b0;
        end else begin
            if (state_q == IDLE && grant_valid) begin
                mem_addr_o  <= sel_addr;
                mem_we_o    <= sel_we;
                mem_wdata_o <= sel_wdata;
                mem_be_o    <= sel_be;
                owner_q     <= grant;
                rr_ptr_q    <= (grant == PW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
            end
            cnt_q <= (state_q == WAIT) ? cnt_q + 8'd1 : '0;
            if (state_q == WAIT && mem_resp_valid_i) begin
                resp_rdata_o <= mem_rdata_i;
                resp_err_o   <= mem_err_i;
            end else if (state_q == WAIT && timeout) begin
                resp_rdata_o <= '0;
                resp_err_o   <= 1'b1;
            end
            if (mem_resp_valid_i && state_q != WAIT) stale_resp_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb_mem_rr_arbiter: directed self-checking bench for mem_rr_arbiter (2 requesters, TIMEOUT=8)
module tb_mem_rr_arbiter;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [1:0]  req_valid_i, req_ready_o, req_we_i, resp_valid_o;
    logic [63:0] req_addr_i, req_wdata_i;
    logic [7:0]  req_be_i;
    logic [31:0] resp_rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic        resp_err_o, mem_req_valid_o, mem_req_ready_i, mem_we_o;
    logic [3:0]  mem_be_o;
    logic        mem_resp_valid_i, mem_err_i, stale_resp_o;
    int          n_tests = 0;
    int          n_fail  = 0;

    mem_rr_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .req_we_i(req_we_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
        .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
        .mem_resp_valid_i(mem_resp_valid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
        .stale_resp_o(stale_resp_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_ni = 1'b0; req_valid_i = '0; req_addr_i = '0; req_we_i = '0; req_wdata_i = '0; req_be_i = '0;
        mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0; mem_rdata_i = '0; mem_err_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        check("rst_ready", req_ready_o, 0);
        check("rst_resp_valid", resp_valid_o, 0);
        check("rst_mem_valid", mem_req_valid_o, 0);
        check("rst_mem_addr", mem_addr_o, 0);
        check("rst_rdata", resp_rdata_o, 0);
        check("rst_stale", stale_resp_o, 0);
        rst_ni = 1'b1;
        // single read, minimum latency
        @(negedge clk_i);
        req_valid_i = 2'b01; req_addr_i[31:0] = 32'h10;
        #1 check("t1_grant", req_ready_o, 2'b01);
        @(negedge clk_i);
        req_valid_i = 2'b00; mem_req_ready_i = 1'b1;
        #1 check("t1_mem_valid", mem_req_valid_o, 1);
        check("t1_mem_addr", mem_addr_o, 32'h10);
        check("t1_mem_we", mem_we_o, 0);
        check("t1_no_ready_issue", req_ready_o, 0);
        @(negedge clk_i);
        mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b1; mem_rdata_i = 32'h101;
        #1 check("t1_wait_mem_valid", mem_req_valid_o, 0);
        check("t1_wait_resp", resp_valid_o, 0);
        @(negedge clk_i);
        mem_resp_valid_i = 1'b0; mem_rdata_i = '0;
        #1 check("t1_resp_valid", resp_valid_o, 2'b01);
        check("t1_rdata", resp_rdata_o, 32'h101);
        check("t1_err", resp_err_o, 0);
        @(negedge clk_i);
        #1 check("t1_resp_drop", resp_valid_o, 0);
        check("t1_rdata_hold", resp_rdata_o, 32'h101);
        check("t1_stale", stale_resp_o, 0);
        // round robin with both requesters always valid
        rst_ni = 1'b0; req_valid_i = 2'b11; req_addr_i = {32'h24, 32'h20};
        #1 rst_ni = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1 check("rr_grant", req_ready_o, (k % 2) ? 2'b10 : 2'b01);
            @(negedge clk_i);
            mem_req_ready_i = 1'b1;
            #1 check("rr_addr", mem_addr_o, (k % 2) ? 32'h24 : 32'h20);
            @(negedge clk_i);
            mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b1; mem_rdata_i = 32'(k);
            @(negedge clk_i);
            mem_resp_valid_i = 1'b0;
            #1 check("rr_resp_owner", resp_valid_o, (k % 2) ? 2'b10 : 2'b01);
            check("rr_rdata", resp_rdata_o, k);
            check("rr_no_grant_in_resp", req_ready_o, 0);
            @(negedge clk_i);
        end
        // write held in ISSUE by a slow memory
        req_valid_i = 2'b10; req_addr_i[63:32] = 32'h14; req_we_i = 2'b10;
        req_wdata_i[63:32] = 32'hDEADBEEF; req_be_i[7:4] = 4'hF;
        #1 check("wr_grant", req_ready_o, 2'b10);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_i);
            mem_req_ready_i = (c == 5);
            req_valid_i = 2'b00; req_addr_i = '1; req_wdata_i = '0; req_be_i = '0; req_we_i = '0;
            #1 check("wr_mem_valid", mem_req_valid_o, 1);
            check("wr_addr", mem_addr_o, 32'h14);
            check("wr_wdata", mem_wdata_o, 32'hDEADBEEF);
            check("wr_be", mem_be_o, 4'hF);
            check("wr_we", mem_we_o, 1);
        end
        @(negedge clk_i);
        mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b1; mem_rdata_i = '0;
        #1 check("wr_wait_mem_valid", mem_req_valid_o, 0);
        @(negedge clk_i);
        mem_resp_valid_i = 1'b0;
        #1 check("wr_resp_owner", resp_valid_o, 2'b10);
        check("wr_err", resp_err_o, 0);
        @(negedge clk_i);
        // timeout with no memory response, then a late response
        req_valid_i = 2'b01; req_addr_i[31:0] = 32'h30;
        #1 check("to_grant", req_ready_o, 2'b01);
        @(negedge clk_i);
        req_valid_i = 2'b00; mem_req_ready_i = 1'b1;
        @(negedge clk_i);
        mem_req_ready_i = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1 check("to_wait_no_resp", resp_valid_o, 0);
            @(negedge clk_i);
        end
        #1 check("to_resp_owner", resp_valid_o, 2'b01);
        check("to_err", resp_err_o, 1);
        check("to_rdata", resp_rdata_o, 0);
        @(negedge clk_i);
        mem_resp_valid_i = 1'b1; mem_rdata_i = 32'hBAD;
        #1 check("to_stale_before", stale_resp_o, 0);
        @(negedge clk_i);
        mem_resp_valid_i = 1'b0;
        #1 check("to_stale_after", stale_resp_o, 1);
        check("to_stale_no_resp", resp_valid_o, 0);
        // response in the last WAIT cycle beats the timeout
        req_valid_i = 2'b10; req_addr_i[63:32] = 32'h40;
        #1 check("tw_grant", req_ready_o, 2'b10);
        @(negedge clk_i);
        req_valid_i = 2'b00; mem_req_ready_i = 1'b1;
        @(negedge clk_i);
        mem_req_ready_i = 1'b0;
        repeat (7) @(negedge clk_i);
        mem_resp_valid_i = 1'b1; mem_rdata_i = 32'h55;
        @(negedge clk_i);
        mem_resp_valid_i = 1'b0;
        #1 check("tw_resp_owner", resp_valid_o, 2'b10);
        check("tw_rdata", resp_rdata_o, 32'h55);
        check("tw_err", resp_err_o, 0);
        check("tw_stale_sticky", stale_resp_o, 1);
        @(negedge clk_i);
        // reset during WAIT
        req_valid_i = 2'b01; req_addr_i[31:0] = 32'h50;
        #1 check("rw_grant", req_ready_o, 2'b01);
        @(negedge clk_i);
        req_valid_i = 2'b00; mem_req_ready_i = 1'b1;
        @(negedge clk_i);
        mem_req_ready_i = 1'b0;
        @(negedge clk_i);
        #1 rst_ni = 1'b0;
        #1 check("rw_resp_valid", resp_valid_o, 0);
        check("rw_mem_valid", mem_req_valid_o, 0);
        check("rw_mem_addr", mem_addr_o, 0);
        check("rw_rdata", resp_rdata_o, 0);
        check("rw_err", resp_err_o, 0);
        check("rw_stale", stale_resp_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        #1 check("rw_no_resp", resp_valid_o, 0);
        mem_resp_valid_i = 1'b1;
        @(negedge clk_i);
        mem_resp_valid_i = 1'b0;
        #1 check("rw_late_stale", stale_resp_o, 1);
        req_valid_i = 2'b11;
        #1 check("rw_grant_req0", req_ready_o, 2'b01);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
